// File: rtl/mdu_pkg.sv
// ----------------------------------------------------------------------------
// mdu_pkg : shared opcodes, FSM state encoding and default latencies for the
//           multiply/divide unit.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ----------------------------------------------------------------------------
// mdu_arith : combinational 64-bit result generator for MULT/DIV (and the
//             MADD family when MDU_MADD_EN is defined).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [63:0] w_hilo;
  logic [31:0] w_squo;
  logic [31:0] w_srem;
  logic [31:0] w_uquo;
  logic [31:0] w_urem;
  logic        w_bz;

  assign w_sprod = 64'($signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b}));
  assign w_uprod = {32'b0, i_a} * {32'b0, i_b};
  assign w_hilo  = {i_hi, i_lo};
  assign w_squo  = 32'($signed(i_a) / $signed(i_b));
  assign w_srem  = 32'($signed(i_a) % $signed(i_b));
  assign w_uquo  = i_a / i_b;
  assign w_urem  = i_a % i_b;
  assign w_bz    = (i_b == 32'd0);

  // A zero divisor re-commits the current HI/LO so completion leaves them intact.
  always_comb begin
    o_res = w_hilo;
    case (i_op)
      MD_MULT:  o_res = w_sprod;
      MD_MULTU: o_res = w_uprod;
      MD_DIV:   o_res = w_bz ? w_hilo : {w_srem, w_squo};
      MD_DIVU:  o_res = w_bz ? w_hilo : {w_urem, w_uquo};
`ifdef MDU_MADD_EN
      MD_MADD:  o_res = w_hilo + w_sprod;
      MD_MADDU: o_res = w_hilo + w_uprod;
      MD_MSUB:  o_res = w_hilo - w_sprod;
      MD_MSUBU: o_res = w_hilo - w_uprod;
`endif
      default:  o_res = w_hilo;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ----------------------------------------------------------------------------
// mdu_ctrl : multiply/divide sequencer owning HI/LO, with busy FSM and D-stage
//            stall.  Optional MADD family via `define MDU_MADD_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdop,
  input  logic        E_start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] E_mdout
);

  mdu_state_t  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic        r_busy;

  logic [3:0]  w_op;
  logic        w_start_op;
  logic        w_go;
  logic [4:0]  w_cnt_load;
  logic [63:0] w_res;

  // Without the option, MADD-family codes collapse to a no-op.
  always_comb begin
    w_op = E_mdop;
`ifdef MDU_MADD_EN
    w_start_op = (E_mdop == MD_MULT) || (E_mdop == MD_MULTU) ||
                 (E_mdop == MD_DIV)  || (E_mdop == MD_DIVU)  ||
                 (E_mdop == MD_MADD) || (E_mdop == MD_MADDU) ||
                 (E_mdop == MD_MSUB) || (E_mdop == MD_MSUBU);
`else
    if ((E_mdop == MD_MADD) || (E_mdop == MD_MADDU) ||
        (E_mdop == MD_MSUB) || (E_mdop == MD_MSUBU)) begin
      w_op = MD_NONE;
    end
    w_start_op = (w_op == MD_MULT) || (w_op == MD_MULTU) ||
                 (w_op == MD_DIV)  || (w_op == MD_DIVU);
`endif
  end

  assign w_go       = E_start & w_start_op & (r_state == S_IDLE);
  assign w_cnt_load = is_div(w_op) ? 5'(DIV_CYCLES) : 5'(MUL_CYCLES);

  mdu_arith u_arith (
    .i_op  (w_op),
    .i_a   (E_A),
    .i_b   (E_B),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .o_res (w_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            {r_phi, r_plo} <= w_res;
            r_cnt          <= w_cnt_load;
            r_state        <= S_BUSY;
            r_busy         <= 1'b1;
          end else if (w_op == MD_MTHI) begin
            r_hi <= E_A;
          end else if (w_op == MD_MTLO) begin
            r_lo <= E_A;
          end
        end
        S_BUSY: begin
          if (r_cnt == 5'd1) begin
            r_hi    <= r_phi;
            r_lo    <= r_plo;
            r_cnt   <= 5'd0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_BUSY)) begin
      assert (!(E_start || (w_op == MD_MTHI) || (w_op == MD_MTLO)))
        else $error("mdu_ctrl: MDU command issued while busy");
    end
  end

  assign busy     = r_busy;
  assign md_stall = D_is_md & (r_busy | E_start);
  assign E_mdout  = (E_mdop == MD_MFHI) ? r_hi :
                    (E_mdop == MD_MFLO) ? r_lo : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mdu_ctrl : directed scoreboard bench for mdu_ctrl (MDU_MADD_EN aware).
//               Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  E_mdop;
  logic        E_start;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] E_mdout;

  int          total;
  int          bad;
  logic [63:0] sb[$];

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_mdop   (E_mdop),
    .E_start  (E_start),
    .E_A      (E_A),
    .E_B      (E_B),
    .D_is_md  (D_is_md),
    .busy     (busy),
    .md_stall (md_stall),
    .E_mdout  (E_mdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    E_mdop = op;
    E_A    = v;
    tick();
    E_mdop = MD_NONE;
  endtask

  task automatic read_hilo(input string tag, input logic [63:0] exp);
    E_mdop = MD_MFHI;
    #1 check({tag, "_hi"}, E_mdout, exp[63:32]);
    E_mdop = MD_MFLO;
    #1 check({tag, "_lo"}, E_mdout, exp[31:0]);
    E_mdop = MD_NONE;
  endtask

  // Returns in the first cycle after completion; with rd=0 the caller may
  // start the next operation in that very cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int n,
                        input logic dmd, input logic rd);
    int          k;
    logic [63:0] e;
    E_mdop  = op;
    E_start = 1'b1;
    E_A     = a;
    E_B     = b;
    D_is_md = dmd;
    #1 check({tag, "_stall_start"}, 32'(md_stall), 32'(dmd));
    sb.push_back(exp);
    tick();
    E_start = 1'b0;
    E_mdop  = MD_NONE;
    k = 0;
    while (busy === 1'b1 && k < 100) begin
      check({tag, "_stall_busy"}, 32'(md_stall), 32'(dmd));
      tick();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(n));
    check({tag, "_stall_done"}, 32'(md_stall), 32'd0);
    e = sb.pop_front();
    if (rd) begin
      read_hilo(tag, e);
      D_is_md = 1'b0;
      tick();
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    E_mdop  = MD_NONE;
    E_start = 1'b0;
    E_A     = 32'd0;
    E_B     = 32'd0;
    D_is_md = 1'b0;
    repeat (2) tick();

    check("rst_busy", 32'(busy), 32'd0);
    read_hilo("rst", 64'd0);
    D_is_md = 1'b1;
    #1 check("rst_stall_idle", 32'(md_stall), 32'd0);
    E_start = 1'b1;
    #1 check("rst_stall_start", 32'(md_stall), 32'd1);
    E_start = 1'b0;
    D_is_md = 1'b0;
    reset   = 1'b0;
    tick();

    run_op("mult",  MD_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, 1'b1, 1'b1);
    run_op("divu",  MD_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 10, 1'b1, 1'b1);
    run_op("div",   MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 1'b1, 1'b1);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 1'b1, 1'b1);

    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    read_hilo("mt", 64'h0000_0011_0000_0022);
    tick();
    run_op("div0",  MD_DIV, 32'd55, 32'd0, 64'h0000_0011_0000_0022, 10, 1'b1, 1'b1);

    run_op("nostall", MD_MULT, 32'd9, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7, 5, 1'b0, 1'b1);

    run_op("b2b_a", MD_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10, 1'b1, 1'b0);
    run_op("b2b_b", MD_MULTU, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 5, 1'b1, 1'b1);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("rmultu", MD_MULTU, ra, rb, {32'b0, ra} * {32'b0, rb}, 5, 1'b1, 1'b1);
      rb = $urandom_range(1, 1000);
      run_op("rdivu", MD_DIVU, ra, rb, {ra % rb, ra / rb}, 10, 1'b1, 1'b1);
    end

    // Reset in the third busy cycle of a DIV discards its result.
    E_mdop  = MD_DIV;
    E_start = 1'b1;
    E_A     = 32'd100;
    E_B     = 32'd3;
    tick();
    E_start = 1'b0;
    E_mdop  = MD_NONE;
    tick();
    tick();
    check("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    read_hilo("rstmid", 64'd0);
    repeat (12) tick();
    check("rstmid_busy_late", 32'(busy), 32'd0);
    read_hilo("rstmid_late", 64'd0);

    mt(MD_MTHI, 32'h0);
    mt(MD_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", MD_MADDU, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 5, 1'b1, 1'b1);
`else
    E_mdop  = MD_MADDU;
    E_start = 1'b1;
    E_A     = 32'd1;
    E_B     = 32'd1;
    tick();
    E_start = 1'b0;
    E_mdop  = MD_NONE;
    check("maddu_off_busy", 32'(busy), 32'd0);
    read_hilo("maddu_off", 64'h0000_0000_FFFF_FFFF);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
